// File: rtl/quad_velocity_meter_pkg.sv
// Shared step encodings, quadrature sequence table and velocity saturation limits
// for the quadrature velocity meter.
package quad_velocity_meter_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DOWN = 2'b10
    } step_e;

    // Forward sequence, AB with A as MSB: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = 2'b10;
            2'b10:   nxt = 2'b11;
            2'b11:   nxt = 2'b01;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_e s;
        if (cur == fwd_next(prev)) begin
            s = STEP_UP;
        end else if (prev == fwd_next(cur)) begin
            s = STEP_DOWN;
        end else begin
            s = STEP_NONE;
        end
        return s;
    endfunction

    function automatic int vel_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int vel_min(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/quad_velocity_meter_sync_filter.sv
// Two-flop synchroniser for one encoder channel, followed by a glitch filter when
// QUAD_FILTER_EN is defined.
module quad_velocity_meter_sync_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic din,
    output logic dout
);

    logic s1_q, s2_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    // A zero-length filter could never pass an edge.
    if (FILT_LEN == 0) begin : g_bad_filt_len
        $error("FILT_LEN must be nonzero");
    end

`ifdef QUAD_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;

    // Counts consecutive samples that disagree with the filtered output.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (s2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
            filt_d = s2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;
`else
    assign dout = s2_q;
`endif

endmodule

// File: rtl/quad_velocity_meter.sv
// 4x quadrature decoder with wrapping position and gated, saturating velocity.
// Define QUAD_FILTER_EN to insert a FILT_LEN-sample glitch filter on each channel.
module quad_velocity_meter
    import quad_velocity_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 1200000,
    parameter int unsigned POS_W       = 16,
    parameter int unsigned VEL_W       = 12,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             i_A,
    input  logic             i_B,
    input  logic             Clear,
    output logic [POS_W-1:0] Position,
    output logic [VEL_W-1:0] Velocity,
    output logic             Vel_valid,
    output logic             Dir,
    output logic             Err
);

    localparam int unsigned       CNT_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [VEL_W-1:0]  ACC_MAX  = VEL_W'(vel_max(VEL_W));
    localparam logic [VEL_W-1:0]  ACC_MIN  = VEL_W'(vel_min(VEL_W));

    logic a_s, b_s;
    logic [1:0] cur_ab;

    quad_velocity_meter_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_a (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .din  (i_A),
        .dout (a_s)
    );

    quad_velocity_meter_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_b (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .din  (i_B),
        .dout (b_s)
    );

    assign cur_ab = {a_s, b_s};

    logic [1:0]       prev_q, prev_d;
    logic             primed_q, primed_d;
    logic [POS_W-1:0] pos_q, pos_d, pos_step;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic [VEL_W-1:0] acc_q, acc_d, acc_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vel_valid_q, vel_valid_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    step_e            step;
    logic             illegal;

    always_comb begin
        step    = STEP_NONE;
        illegal = 1'b0;
        if (primed_q) begin
            step    = decode_step(prev_q, cur_ab);
            illegal = (cur_ab != prev_q) && (step == STEP_NONE);
        end
    end

    // Position wraps freely; the window accumulator clamps at the signed limits.
    always_comb begin
        unique case (step)
            STEP_UP: begin
                pos_step = pos_q + 1'b1;
                acc_step = (acc_q == ACC_MAX) ? acc_q : acc_q + 1'b1;
            end
            STEP_DOWN: begin
                pos_step = pos_q - 1'b1;
                acc_step = (acc_q == ACC_MIN) ? acc_q : acc_q - 1'b1;
            end
            default: begin
                pos_step = pos_q;
                acc_step = acc_q;
            end
        endcase
    end

    always_comb begin
        prev_d      = prev_q;
        primed_d    = primed_q;
        pos_d       = pos_q;
        vel_d       = vel_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        vel_valid_d = 1'b0;
        dir_d       = dir_q;
        err_d       = err_q;
        if (Clear) begin
            pos_d    = '0;
            err_d    = 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
            primed_d = 1'b0;
        end else begin
            primed_d = 1'b1;
            prev_d   = cur_ab;
            pos_d    = pos_step;
            if (step != STEP_NONE) begin
                dir_d = (step == STEP_UP);
            end
            if (illegal) begin
                err_d = 1'b1;
            end
            // A step on the closing cycle still belongs to the closing window.
            if (cnt_q == CNT_LAST) begin
                vel_d       = acc_step;
                acc_d       = '0;
                cnt_d       = '0;
                vel_valid_d = 1'b1;
            end else begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prev_q      <= '0;
            primed_q    <= 1'b0;
            pos_q       <= '0;
            vel_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            vel_valid_q <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            primed_q    <= primed_d;
            pos_q       <= pos_d;
            vel_q       <= vel_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            vel_valid_q <= vel_valid_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
        end
    end

    assign Position  = pos_q;
    assign Velocity  = vel_q;
    assign Vel_valid = vel_valid_q;
    assign Dir       = dir_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_quad_velocity_meter.sv
// Self-checking bench for quad_velocity_meter: directed cases plus random encoder traffic,
// checked against a sample-history reference model and a velocity scoreboard.
module tb_quad_velocity_meter;

    localparam int GATE = 100;
    localparam int PW   = 8;
    localparam int VW   = 6;
    localparam int FL   = 4;
`ifdef QUAD_FILTER_EN
    localparam int LAT  = 3 + FL;
    localparam int MINH = FL + 1;
    localparam int SP   = FL + 1;
`else
    localparam int LAT  = 3;
    localparam int MINH = 1;
    localparam int SP   = 2;
`endif
    localparam int VMAX  = (1 << (VW - 1)) - 1;
    localparam int VMIN  = -(1 << (VW - 1));
    localparam int VMASK = (1 << VW) - 1;
    localparam int PMASK = (1 << PW) - 1;

    logic          Clk   = 1'b0;
    logic          Rst_n = 1'b1;
    logic          i_A   = 1'b0;
    logic          i_B   = 1'b0;
    logic          Clear = 1'b0;
    logic [PW-1:0] Position;
    logic [VW-1:0] Velocity;
    logic          Vel_valid;
    logic          Dir;
    logic          Err;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    quad_velocity_meter #(
        .GATE_CYCLES(GATE),
        .POS_W      (PW),
        .VEL_W      (VW),
        .FILT_LEN   (FL)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .i_A      (i_A),
        .i_B      (i_B),
        .Clear    (Clear),
        .Position (Position),
        .Velocity (Velocity),
        .Vel_valid(Vel_valid),
        .Dir      (Dir),
        .Err      (Err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ab2idx(input bit [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit [1:0] idx2ab(input int i);
        case (i)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int sat(input int v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    int       m_pos, m_acc, m_vel, m_cnt, m_prev;
    bit       m_dir, m_err, m_vv, m_primed;
    bit [1:0] m_filt;
    bit [1:0] hist[$];
    int       exp_q[$];

    task automatic model_reset();
        m_pos = 0; m_acc = 0; m_vel = 0; m_cnt = 0; m_prev = 0;
        m_dir = 0; m_err = 0; m_vv = 0; m_primed = 0; m_filt = 2'b00;
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(2'b00);
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit [1:0] seen;
        int       step;
        int       d;
        hist.push_front({i_A, i_B});
        void'(hist.pop_back());
`ifdef QUAD_FILTER_EN
        seen = m_filt;
        // A channel value is accepted once it has been seen FL times running.
        for (int ch = 0; ch < 2; ch++) begin
            bit same = 1'b1;
            for (int j = 3; j < FL + 2; j++) if (hist[j][ch] != hist[2][ch]) same = 1'b0;
            if (same) m_filt[ch] = hist[2][ch];
        end
`else
        seen = hist[2];
`endif
        m_vv = 1'b0;
        if (Clear) begin
            m_pos = 0; m_err = 0; m_acc = 0; m_cnt = 0; m_primed = 0;
        end else begin
            step = 0;
            if (m_primed) begin
                d = (ab2idx(seen) - m_prev + 4) % 4;
                if (d == 1) step = 1;
                else if (d == 3) step = -1;
                else if (d == 2) m_err = 1'b1;
            end
            m_prev   = ab2idx(seen);
            m_primed = 1'b1;
            m_pos    = (m_pos + step) & PMASK;
            if (step != 0) m_dir = (step > 0);
            if (m_cnt == GATE - 1) begin
                m_vel = sat(m_acc + step);
                exp_q.push_back(m_vel);
                m_acc = 0;
                m_cnt = 0;
                m_vv  = 1'b1;
            end else begin
                m_acc = sat(m_acc + step);
                m_cnt++;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clk or negedge Rst_n);
            if (!Rst_n) model_reset();
            else model_edge();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge Clk);
            if (Rst_n) begin
                check("position", 32'(Position), 32'(m_pos));
                check("dir", 32'(Dir), 32'(m_dir));
                check("err", 32'(Err), 32'(m_err));
                check("velocity", 32'(Velocity), 32'(m_vel & VMASK));
                check("vel_valid", 32'(Vel_valid), 32'(m_vv));
                if (Vel_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_vel_valid actual=%0h required=none",
                                 Velocity);
                    end else begin
                        check("sb_velocity", 32'(Velocity), 32'(exp_q.pop_front() & VMASK));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int idx = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic drive_idx(input int d, input int hold);
        idx = (idx + d + 4) % 4;
        {i_A, i_B} = idx2ab(idx);
        tick(hold);
    endtask

    task automatic clear_pulse();
        Clear = 1'b1;
        tick(1);
        Clear = 1'b0;
    endtask

    task automatic wait_vv();
        bit found = 1'b0;
        for (int i = 0; i < 3 * GATE; i++) begin
            tick(1);
            if (Vel_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_vel_valid", 32'(found), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_position"}, 32'(Position), 32'd0);
        check({tag, "_velocity"}, 32'(Velocity), 32'd0);
        check({tag, "_vel_valid"}, 32'(Vel_valid), 32'd0);
        check({tag, "_dir"}, 32'(Dir), 32'd0);
        check({tag, "_err"}, 32'(Err), 32'd0);
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            int r = $urandom_range(0, 99);
            int hold = $urandom_range(MINH, 6);
            if (r < 45) drive_idx(1, hold);
            else if (r < 85) drive_idx(-1, hold);
            else if (r < 90) drive_idx(2, hold);
            else if (r < 94) begin
                clear_pulse();
                tick(hold);
            end else tick(hold);
        end
    endtask

    initial begin
        #1 Rst_n = 1'b0;
        #10 check_all_zero("reset");
        #1 Rst_n = 1'b1;
        tick(2);

        // 12 forward steps inside one window
        clear_pulse();
        repeat (12) drive_idx(1, 5);
        tick(LAT);
        check("fwd12_position", 32'(Position), 32'd12);
        check("fwd12_dir", 32'(Dir), 32'd1);
        wait_vv();
        check("fwd12_velocity", 32'(Velocity), 32'd12);

        // 3 reverse steps from zero
        clear_pulse();
        repeat (3) drive_idx(-1, 5);
        tick(LAT);
        check("rev3_position", 32'(Position), 32'hFD);
        check("rev3_dir", 32'(Dir), 32'd0);
        wait_vv();
        check("rev3_velocity", 32'(Velocity), 32'h3D);

        // both channels toggling together
        clear_pulse();
        tick(2);
        drive_idx(2, LAT + 2);
        check("illegal_position", 32'(Position), 32'd0);
        check("illegal_err", 32'(Err), 32'd1);
        clear_pulse();
        check("clear_err", 32'(Err), 32'd0);
        check("clear_position", 32'(Position), 32'd0);

        // step decoded exactly on the window-close cycle
        clear_pulse();
        tick(GATE - LAT);
        drive_idx(1, LAT);
        check("edge_close_vv", 32'(Vel_valid), 32'd1);
        check("edge_close_velocity", 32'(Velocity), 32'd1);
        tick(GATE);
        check("next_window_vv", 32'(Vel_valid), 32'd1);
        check("next_window_velocity", 32'(Velocity), 32'd0);

        // Clear on the close cycle wins: no pulse, Velocity held
        clear_pulse();
        drive_idx(1, 10);
        tick(GATE - 1 - 10);
        clear_pulse();
        check("clear_close_vv", 32'(Vel_valid), 32'd0);
        check("clear_close_velocity", 32'(Velocity), 32'd0);
        wait_vv();
        check("after_clear_close_velocity", 32'(Velocity), 32'd0);

        // saturation
        clear_pulse();
        repeat (40) drive_idx(1, SP);
        wait_vv();
`ifndef QUAD_FILTER_EN
        check("sat_velocity", 32'(Velocity), 32'd31);
`endif

        // position wrap 0x7F -> 0x80
        clear_pulse();
        repeat (127) drive_idx(1, SP);
        tick(LAT);
        check("wrap_pos_7f", 32'(Position), 32'h7F);
        drive_idx(1, LAT + 1);
        check("wrap_pos_80", 32'(Position), 32'h80);

`ifdef QUAD_FILTER_EN
        i_A = ~i_A;
        tick(2);
        i_A = ~i_A;
        tick(12);
        check("glitch_position", 32'(Position), 32'h80);
        drive_idx(1, 6);
        check("filt_pos_6clk", 32'(Position), 32'h80);
        tick(1);
        check("filt_pos_7clk", 32'(Position), 32'h81);
`endif

        random_traffic(500);

        // reset mid-window discards the partial window
        repeat (5) drive_idx(1, MINH + 1);
        #2 Rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        idx = 0;
        {i_A, i_B} = 2'b00;
        tick(2);
        #3 Rst_n = 1'b1;
        tick(1);
        random_traffic(60);
        tick(GATE + 10);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
